// File: rtl/wb_if.sv
// Writeback arbiter bus: pipeline WB request, LSU result handshake and the
// regfile write port, plus the hazard-unit status outputs.
interface wb_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            alu_we;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_wd;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_wd;
    logic            we3;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    logic [31:0]     pend_mask;
    logic [CW-1:0]   buf_count;

    modport master (
        output alu_we, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
        input  lsu_ready, we3, a3, wd3, pend_mask, buf_count
    );

    modport slave (
        input  alu_we, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
        output lsu_ready, we3, a3, wd3, pend_mask, buf_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Regfile writeback arbiter: ALU writes win, LSU results queue in a FIFO and
// drain when the port is free. Optional same-cycle LSU bypass: WB_BYPASS_EN.
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    wb_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      r_rd   [DEPTH];
    logic [XLEN-1:0] r_wd   [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_pend;

    logic             w_alu_wr;
    logic             w_empty;
    logic             w_full;
    logic             w_ready;
    logic             w_pop;
    logic             w_bypass;
    logic             w_push;
    logic             w_push_vld;
    logic [DEPTH-1:0] w_vld_nxt;
    logic [31:0]      w_pend_nxt;

    assign w_alu_wr   = bus.alu_we && (bus.alu_rd != 5'd0);
    assign w_empty    = (r_count == {CW{1'b0}});
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_ready    = rst_n && !w_full;
    assign w_pop      = !w_alu_wr && !w_empty;
`ifdef WB_BYPASS_EN
    assign w_bypass   = !w_alu_wr && w_empty && bus.lsu_valid && (bus.lsu_rd != 5'd0);
`else
    assign w_bypass   = 1'b0;
`endif
    // x0 results complete the handshake but never occupy a slot
    assign w_push     = bus.lsu_valid && w_ready && (bus.lsu_rd != 5'd0) && !w_bypass;
    assign w_push_vld = !(w_alu_wr && (bus.alu_rd == bus.lsu_rd));

    assign bus.lsu_ready = w_ready;
    assign bus.buf_count = r_count;
    assign bus.pend_mask = r_pend;

    // Next-cycle entry valid bits (kill, pop, push) and the derived pending mask
    always_comb begin
        w_vld_nxt  = {DEPTH{1'b0}};
        w_pend_nxt = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wr_ptr == PW'(i))) begin
                w_vld_nxt[i] = w_push_vld;
                w_pend_nxt   = w_pend_nxt | (w_push_vld ? (32'd1 << bus.lsu_rd) : 32'd0);
            end else begin
                w_vld_nxt[i] = r_vld[i]
                             && !(w_alu_wr && (r_rd[i] == bus.alu_rd))
                             && !(w_pop && (r_rd_ptr == PW'(i)));
                w_pend_nxt   = w_pend_nxt | (w_vld_nxt[i] ? (32'd1 << r_rd[i]) : 32'd0);
            end
        end
    end

    // Write-port mux: ALU first, then FIFO head, then (optionally) live LSU result
    always_comb begin
        bus.we3 = 1'b0;
        bus.a3  = 5'd0;
        bus.wd3 = {XLEN{1'b0}};
        if (!rst_n) begin
            bus.we3 = 1'b0;
        end else if (w_alu_wr) begin
            bus.we3 = 1'b1;
            bus.a3  = bus.alu_rd;
            bus.wd3 = bus.alu_wd;
        end else if (!w_empty) begin
            bus.we3 = r_vld[r_rd_ptr];
            bus.a3  = r_rd[r_rd_ptr];
            bus.wd3 = r_wd[r_rd_ptr];
        end else if (w_bypass) begin
            bus.we3 = 1'b1;
            bus.a3  = bus.lsu_rd;
            bus.wd3 = bus.lsu_wd;
        end else begin
            bus.we3 = 1'b0;
        end
    end

    // FIFO storage, pointers, occupancy and pending mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_vld    <= {DEPTH{1'b0}};
            r_pend   <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i] <= 5'd0;
                r_wd[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_rd[r_wr_ptr] <= bus.lsu_rd;
                r_wd[r_wr_ptr] <= bus.lsu_wd;
                r_wr_ptr       <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_vld   <= w_vld_nxt;
            r_pend  <= w_pend_nxt;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model, per-cycle
// compare on the falling edge, directed scenarios and randomized traffic.
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
        bit          v;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] m_rf [32];
    logic [31:0] d_rf [32];
    ent_t        q[$];

    wb_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a queue of {rd, data, live}
    bit   m_alu, m_acc, m_byp;
    ent_t m_e;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            m_alu = bus.alu_we && (bus.alu_rd != 5'd0);
            m_acc = bus.lsu_valid && (q.size() < DEPTH);
            m_byp = BYP && !m_alu && (q.size() == 0) && bus.lsu_valid && (bus.lsu_rd != 5'd0);
            if (m_alu) begin
                foreach (q[k]) if (q[k].rd == bus.alu_rd) q[k].v = 1'b0;
                m_rf[bus.alu_rd] = bus.alu_wd;
            end else if (q.size() > 0) begin
                m_e = q.pop_front();
                if (m_e.v) m_rf[m_e.rd] = m_e.wd;
            end else if (m_byp) begin
                m_rf[bus.lsu_rd] = bus.lsu_wd;
            end
            if (m_acc && (bus.lsu_rd != 5'd0) && !m_byp)
                q.push_back('{bus.lsu_rd, bus.lsu_wd, !(m_alu && (bus.alu_rd == bus.lsu_rd))});
        end
    end

    // Per-cycle compare at the regfile sampling edge
    bit          c_alu, c_byp, c_we;
    logic [4:0]  c_a3;
    logic [31:0] c_wd, c_pend;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_we3", bus.we3, 1'b0);
            chk("rst_count", bus.buf_count, 0);
            chk("rst_pend", bus.pend_mask, 0);
            chk("rst_ready", bus.lsu_ready, 1'b0);
        end else begin
            c_alu  = bus.alu_we && (bus.alu_rd != 5'd0);
            c_byp  = BYP && !c_alu && (q.size() == 0) && bus.lsu_valid && (bus.lsu_rd != 5'd0);
            c_pend = 32'd0;
            foreach (q[k]) if (q[k].v) c_pend[q[k].rd] = 1'b1;
            c_we = 1'b0; c_a3 = 5'd0; c_wd = 32'd0;
            if (c_alu) begin
                c_we = 1'b1; c_a3 = bus.alu_rd; c_wd = bus.alu_wd;
            end else if (q.size() > 0) begin
                c_we = q[0].v; c_a3 = q[0].rd; c_wd = q[0].wd;
            end else if (c_byp) begin
                c_we = 1'b1; c_a3 = bus.lsu_rd; c_wd = bus.lsu_wd;
            end
            chk("we3", bus.we3, c_we);
            if (c_we) begin
                chk("a3", bus.a3, c_a3);
                chk("wd3", bus.wd3, c_wd);
            end
            chk("count", bus.buf_count, q.size());
            chk("ready", bus.lsu_ready, q.size() < DEPTH);
            chk("pend_mask", bus.pend_mask, c_pend);
            chk("x0_write", bus.we3 && (bus.a3 == 5'd0), 1'b0);
            if (bus.we3) d_rf[bus.a3] = bus.wd3;
        end
    end

    task automatic set_in(input logic awe, input logic [4:0] ard, input logic [31:0] awd,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
        bus.alu_we = awe; bus.alu_rd = ard; bus.alu_wd = awd;
        bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_wd = lwd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 20 && bus.buf_count != 0; k++) step();
        chk("drain_done", bus.buf_count, 0);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin m_rf[r] = 32'd0; d_rf[r] = 32'd0; end
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2 chk("ready_after_reset", bus.lsu_ready, 1'b1);
        step();

        // Reset with three buffered entries
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'd9, 32'h90 + 32'(i), 1'b1, 5'(10 + i), 32'hB0 + 32'(i));
            step();
        end
        chk("t1_count3", bus.buf_count, 3);
        rst_n = 1'b0;
        #2;
        chk("t1_we3", bus.we3, 1'b0);
        chk("t1_count", bus.buf_count, 0);
        chk("t1_pend", bus.pend_mask, 0);
        chk("t1_ready", bus.lsu_ready, 1'b0);
        step();
        rst_n = 1'b1;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2 chk("t1_ready_rel", bus.lsu_ready, 1'b1);
        step();

        // Fill behind a busy ALU, then drain in order
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 5'd9, 32'h99, 1'b1, 5'(i), 32'h100 + 32'(i));
            step();
        end
        chk("t2_count", bus.buf_count, 4);
        chk("t2_ready", bus.lsu_ready, 1'b0);
        chk("t2_pend", bus.pend_mask, 32'h1E);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (4) step();
        for (int i = 1; i <= 4; i++) chk("t2_rf", d_rf[i], 32'h100 + 32'(i));
        chk("t2_empty", bus.buf_count, 0);

        // Kill a buffered write with a newer ALU write
        set_in(1'b1, 5'd9, 32'h9, 1'b1, 5'd5, 32'hAAAA);
        step();
        chk("t3_pend_set", bus.pend_mask, 32'h20);
        set_in(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        step();
        chk("t3_pend_clr", bus.pend_mask, 0);
        chk("t3_count", bus.buf_count, 1);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2 chk("t3_killed_we3", bus.we3, 1'b0);
        step();
        chk("t3_count0", bus.buf_count, 0);
        chk("t3_x5", d_rf[5], 32'h1234);

        // Same-cycle collision on x7
        set_in(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        #2;
        chk("t4_we3", bus.we3, 1'b1);
        chk("t4_a3", bus.a3, 7);
        chk("t4_wd3", bus.wd3, 32'h11);
        step();
        chk("t4_count", bus.buf_count, 1);
        chk("t4_pend", bus.pend_mask, 0);
        drain();
        chk("t4_x7", d_rf[7], 32'h11);

        // LSU result to x0 is accepted and dropped
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
        #2 chk("t5_ready", bus.lsu_ready, 1'b1);
        step();
        chk("t5_count", bus.buf_count, 0);
        chk("t5_pend", bus.pend_mask, 0);

        // Empty FIFO, idle ALU, LSU x3
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h55);
        #2 chk("t6_we3_now", bus.we3, BYP);
        step();
        chk("t6_count", bus.buf_count, BYP ? 0 : 1);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2 chk("t6_we3_next", bus.we3, !BYP);
        step();
        chk("t6_x3", d_rf[3], 32'h55);
        chk("t6_x0", d_rf[0], 32'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 800; n++) begin
            set_in(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom(),
                   ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom());
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end
        drain();
        for (int r = 0; r < 32; r++) chk("final_rf", d_rf[r], m_rf[r]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
